// File: rtl/xeng_acc_sched_pkg.sv
// Shared types and helpers for the X-engine window scheduler.
package xeng_sched_pkg;

  // Width of an antenna index on the tag outputs (covers up to 256 antennas).
  localparam int ANT_IDX_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Baseline pair currently being enumerated; b never exceeds a.
  typedef struct packed {
    logic [ANT_IDX_W-1:0] a;
    logic [ANT_IDX_W-1:0] b;
  } bl_pair_t;

  // Number of baselines (autos included) produced per accumulation window.
  function automatic int NBL(input int n_ants);
    return n_ants * (n_ants + 1) / 2;
  endfunction

endpackage

// File: rtl/xeng_acc_sched_if.sv
// Stream-side signals of the window scheduler: chain input framing,
// tap-chain sync, chain output valid and the per-word tags.
interface xeng_acc_sched_if #(
  parameter int N_CHANS_BITS = 8
);
  import xeng_sched_pkg::*;

  logic                    sync_in;
  logic                    din_valid;
  logic                    tap_sync;
  logic                    acc_valid_in;
  logic                    out_valid;
  logic [N_CHANS_BITS-1:0] out_chan;
  logic [ANT_IDX_W-1:0]    out_ant_a;
  logic [ANT_IDX_W-1:0]    out_ant_b;
  logic                    out_last;
  logic                    err_misalign;
  logic                    err_tag_ovf;
  logic                    err_tag_unf;

  // Environment side: drives framing and chain valid, observes tags.
  modport master (
    output sync_in, din_valid, acc_valid_in,
    input  tap_sync, out_valid, out_chan, out_ant_a, out_ant_b, out_last,
           err_misalign, err_tag_ovf, err_tag_unf
  );

  // Scheduler side.
  modport slave (
    input  sync_in, din_valid, acc_valid_in,
    output tap_sync, out_valid, out_chan, out_ant_a, out_ant_b, out_last,
           err_misalign, err_tag_ovf, err_tag_unf
  );

endinterface

// File: rtl/xeng_acc_sched_tag_fifo.sv
// Small register FIFO holding channel tags of windows that have started
// on the chain input but whose accumulations have not yet drained.
// A push into a full FIFO is accepted only if a pop happens the same cycle.
module sched_tag_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  // Next-state: write at the tail, advance head on pop, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xeng_acc_sched.sv
// Window scheduler for the X-engine tap chain: frames the input sample
// stream into 2^SERIAL_ACC_LEN_BITS-sample windows, pulses tap_sync at each
// window start, and tags every chain output word with channel and baseline.
//
// state | meaning
// IDLE  | waiting for the first qualified sync_in; nothing is framed
// RUN   | framing windows; left only through rst
module xeng_acc_sched
  import xeng_sched_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 32,
  parameter int N_CHANS_BITS        = 8,
  parameter int TAG_FIFO_DEPTH_BITS = 2
) (
  input logic              clk,
  input logic              rst,
  input logic              ce,
  xeng_acc_sched_if.slave  bus
);

  localparam logic [0:0]           S_IDLE   = IDLE;
  localparam logic [0:0]           S_RUN    = RUN;
  localparam logic [ANT_IDX_W-1:0] LAST_ANT = ANT_IDX_W'(N_ANTS - 1);

  logic [0:0]                     state_q, state_d;
  logic [SERIAL_ACC_LEN_BITS-1:0] scnt_q, scnt_d;
  logic [N_CHANS_BITS-1:0]        chan_q, chan_d;
  bl_pair_t                       pair_q, pair_d;

  logic                    tap_sync_q, tap_sync_d;
  logic                    out_valid_q, out_valid_d;
  logic [N_CHANS_BITS-1:0] out_chan_q, out_chan_d;
  logic [ANT_IDX_W-1:0]    out_ant_a_q, out_ant_a_d;
  logic [ANT_IDX_W-1:0]    out_ant_b_q, out_ant_b_d;
  logic                    out_last_q, out_last_d;
  logic                    err_misalign_q, err_misalign_d;
  logic                    err_tag_ovf_q, err_tag_ovf_d;
  logic                    err_tag_unf_q, err_tag_unf_d;

  logic                    sync_hit, misalign, win_start, acc_last, in_run;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_drop;
  logic [N_CHANS_BITS-1:0] fifo_head;

  // Decode window starts, resyncs and end-of-window on the chain output.
  always_comb begin
    in_run    = (state_q == S_RUN);
    sync_hit  = bus.sync_in && bus.din_valid;
    misalign  = in_run && sync_hit && (scnt_q != '0);
    win_start = in_run ? (bus.din_valid && (bus.sync_in || (scnt_q == '0)))
                       : sync_hit;
    acc_last  = (pair_q.a == LAST_ANT) && (pair_q.b == LAST_ANT);
    fifo_push = ce && win_start;
    fifo_pop  = ce && bus.acc_valid_in && acc_last;
  end

  sched_tag_fifo #(
    .WIDTH      (N_CHANS_BITS),
    .DEPTH_BITS (TAG_FIFO_DEPTH_BITS)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (chan_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Next-state for FSM, sample counter, channel counter and enumerator.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    chan_d  = chan_q;
    pair_d  = pair_q;

    if (!in_run && sync_hit) state_d = S_RUN;

    // The window-start sample is sample 0, so the counter leaves it at 1;
    // a resync restarts the count from that sample.
    if (win_start || (in_run && bus.din_valid)) begin
      scnt_d = (win_start ? '0 : scnt_q) + 1'b1;
    end

    if (win_start) chan_d = chan_q + 1'b1;

    if (bus.acc_valid_in) begin
      if (acc_last) begin
        pair_d = '0;
      end else if (pair_q.b == pair_q.a) begin
        pair_d.a = pair_q.a + 1'b1;
        pair_d.b = '0;
      end else begin
        pair_d.b = pair_q.b + 1'b1;
      end
    end
  end

  // Next-state for the registered outputs and sticky error flags.
  always_comb begin
    tap_sync_d     = win_start;
    out_valid_d    = bus.acc_valid_in;
    out_last_d     = bus.acc_valid_in && acc_last;
    out_chan_d     = out_chan_q;
    out_ant_a_d    = out_ant_a_q;
    out_ant_b_d    = out_ant_b_q;
    err_misalign_d = err_misalign_q || misalign;
    err_tag_ovf_d  = err_tag_ovf_q || fifo_drop;
    err_tag_unf_d  = err_tag_unf_q || (bus.acc_valid_in && fifo_empty);

    // Words arriving with no pending window are still tagged, as channel 0.
    if (bus.acc_valid_in) begin
      out_chan_d  = fifo_empty ? '0 : fifo_head;
      out_ant_a_d = pair_q.a;
      out_ant_b_d = pair_q.b;
    end
  end

  // All state registers; ce low freezes everything, rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      scnt_q         <= '0;
      chan_q         <= '0;
      pair_q         <= '0;
      tap_sync_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_chan_q     <= '0;
      out_ant_a_q    <= '0;
      out_ant_b_q    <= '0;
      out_last_q     <= 1'b0;
      err_misalign_q <= 1'b0;
      err_tag_ovf_q  <= 1'b0;
      err_tag_unf_q  <= 1'b0;
    end else if (ce) begin
      state_q        <= state_d;
      scnt_q         <= scnt_d;
      chan_q         <= chan_d;
      pair_q         <= pair_d;
      tap_sync_q     <= tap_sync_d;
      out_valid_q    <= out_valid_d;
      out_chan_q     <= out_chan_d;
      out_ant_a_q    <= out_ant_a_d;
      out_ant_b_q    <= out_ant_b_d;
      out_last_q     <= out_last_d;
      err_misalign_q <= err_misalign_d;
      err_tag_ovf_q  <= err_tag_ovf_d;
      err_tag_unf_q  <= err_tag_unf_d;
    end
  end

  assign bus.tap_sync     = tap_sync_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_chan     = out_chan_q;
  assign bus.out_ant_a    = out_ant_a_q;
  assign bus.out_ant_b    = out_ant_b_q;
  assign bus.out_last     = out_last_q;
  assign bus.err_misalign = err_misalign_q;
  assign bus.err_tag_ovf  = err_tag_ovf_q;
  assign bus.err_tag_unf  = err_tag_unf_q;

endmodule

// File: doc/xeng_acc_sched.md
# xeng_acc_sched

Window scheduler for the X-engine baseline-tap chain. It frames the incoming antenna sample stream into serial-accumulation windows and issues the per-window sync pulse that resets the tap chain's accumulators. It also tags every accumulation word leaving the end of the chain with its (channel, antenna-a, antenna-b) index, so the downstream packetiser never has to rederive ordering. It sits between the F-engine input reorder and the tap chain's sync input, and between the chain's `valid_out` and the readout logic.

## Interface
Parameters:
- `SERIAL_ACC_LEN_BITS`, 7: serial accumulation length per window is 2^N samples.
- `N_ANTS`, 32: dual-pol antenna inputs; 2..256.
- `N_CHANS_BITS`, 8: channel-tag width; channel counter wraps at 2^N.
- `TAG_FIFO_DEPTH_BITS`, 2: depth of the pending-channel tag FIFO is 2^N.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `ce`, in, 1: clock enable; all state holds when low.
- `sync_in`, in, 1: frame start from upstream; qualified by `din_valid`.
- `din_valid`, in, 1: an antenna sample is present on the chain input this cycle.
- `tap_sync`, out, 1: one-cycle window-start pulse to the tap chain `sync_in`.
- `acc_valid_in`, in, 1: `valid_out` from the last tap.
- `out_valid`, out, 1: tag outputs are valid.
- `out_chan`, out, `N_CHANS_BITS`: channel of the current accumulation word.
- `out_ant_a`, out, 8: first antenna index.
- `out_ant_b`, out, 8: second antenna index; always ≤ `out_ant_a`.
- `out_last`, out, 1: last baseline of a window.
- `err_misalign`, out, 1: sticky flag.
- `err_tag_ovf`, out, 1: sticky flag.
- `err_tag_unf`, out, 1: sticky flag.

## Operation
- Reset behaviour: all outputs 0; state IDLE; counters and FIFO are cleared.
- State machine:
  - IDLE → RUN when `sync_in & din_valid`. That cycle is sample 0 of window 0 with channel 0.
  - RUN → RUN: never leaves RUN except through `rst`.
- Sample counter `scnt`, SERIAL_ACC_LEN_BITS wide:
  - Increments on each `din_valid` cycle in RUN.
  - Holds through gaps in `din_valid`.
  - Wraps from 2^N−1 to 0.
- Window start occurs on a `din_valid` cycle with `scnt==0`, including the IDLE→RUN cycle. At each window start:
  - Pulse `tap_sync`.
  - Push the current channel into the tag FIFO.
  - Increment the channel counter, modulo 2^N_CHANS_BITS.
- Resync when `sync_in & din_valid` arrives in RUN with `scnt≠0`:
  - Set `err_misalign`.
  - Force `scnt` to 0.
  - Treat the cycle as a window start; the channel counter is not reset.
- `sync_in` arriving in RUN with `scnt==0` is a normal window start with no error.
- Baseline enumeration per window, NBL = N_ANTS·(N_ANTS+1)/2 words:
  - Starts at (a,b) = (0,0).
  - On each `acc_valid_in`: if `b==a`, then `a←a+1`, `b←0`; otherwise `b←b+1`.
  - `out_last` is asserted for (N_ANTS−1, N_ANTS−1). That word pops the tag FIFO, and a/b return to 0.
- `out_chan` is the FIFO head, held for the whole window.
- Tag FIFO overflow: a push with the FIFO full sets `err_tag_ovf` and drops the push.
- Tag FIFO underflow: `acc_valid_in` with the FIFO empty sets `err_tag_unf`. The word is still tagged with `out_chan`=0 and enumeration still advances.
- Push and pop in the same cycle are both performed, and the occupancy is unchanged. This also holds when the FIFO is full.
- Sticky error flags clear only on `rst`.

## Timing
- `tap_sync` is registered and asserts 1 cycle after the qualifying `din_valid` cycle. The chain-input data path carries a matching 1-cycle register outside this block.
- `out_*` are registered and appear 1 cycle after `acc_valid_in`; `out_valid` is `acc_valid_in` delayed by 1.
- `acc_valid_in` words may arrive back-to-back or with gaps; no backpressure.
- `ce` low freezes every register, including output registers; `ce` is ANDed into every enable.
- `rst` asserted mid-window:
  - Next cycle, all outputs are 0 and the FIFO is empty.
  - Any partial window from the chain is subsequently tagged from (0,0) and will flag underflow if no new window started.

## Structure
- Package `xeng_sched_pkg`:
  - `NBL` function.
  - Index-width constant `ANT_IDX_W`=8.
  - State enum {IDLE, RUN}.
- Sub-module `sched_tag_fifo`: synchronous register FIFO with width `N_CHANS_BITS`, depth 2^TAG_FIFO_DEPTH_BITS, push/pop/full/empty, and same-cycle push+pop support.
- Top level contains the FSM, `scnt`, the channel counter and the baseline enumerator.

## Test plan
- **Basic framing** (N=7, N_ANTS=4): `sync_in` + 300 contiguous `din_valid` → `tap_sync` pulses at cycles 1, 129, 257 relative to the sync; channels 0, 1, 2 are pushed.
- **Gapped input**: `din_valid` 50% duty → `tap_sync` spacing is 256 cycles; `scnt` holds through gaps.
- **Tagging** (N_ANTS=4): one window, then 10 `acc_valid_in` → pairs (0,0) (1,0) (1,1) (2,0) (2,1) (2,2) (3,0) (3,1) (3,2) (3,3); `out_last` on the 10th word; `out_chan`=0; the next window is tagged `out_chan`=1.
- **Misaligned sync**: `sync_in` at `scnt`=37 → `err_misalign`=1, `tap_sync` the next cycle, channel continues incrementing.
- **FIFO limits**:
  - 5 windows with no `acc_valid_in` (depth 4) → `err_tag_ovf` on the 5th push.
  - `acc_valid_in` after reset with no sync → `err_tag_unf`.
  - Push and pop on the same cycle with the FIFO full → no error.
- **Reset and ce**:
  - `rst` at tag (2,1) → outputs 0, enumeration restarts at (0,0).
  - `ce`=0 for 5 cycles mid-window → all outputs and counters frozen.
